// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Pipeline hazard controller for the RV32IM 5-stage core. It produces the
// PC / IF/ID / ID/EX stall and flush controls that operand bypassing cannot
// resolve on its own:
//   - load-use hazards (one bubble into ID/EX while PC and IF/ID hold),
//   - multi-cycle M-extension operations (start/done handshake with the
//     mul/div unit; EX is frozen until done),
//   - taken branch / jump redirects (IF/ID and ID/EX flushed).
// It also keeps two saturating performance counters.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   id_rs1/rs2_addr_i       source registers of the ID instruction
//   id_uses_rs1/rs2_i       ID instruction really reads that source
//   id_ex_mem_read_i        EX instruction is a load
//   id_ex_rd_addr_i         destination register of the EX instruction
//   id_ex_is_muldiv_i       EX instruction is MUL*/DIV*/REM*
//   muldiv_done_i           mul/div result valid this cycle
//   ex_branch_taken_i       EX resolved a taken branch / jump
//   pc_stall_o, if_id_stall_o, id_ex_stall_o   hold controls
//   if_id_flush_o, id_ex_flush_o               flush controls
//   ex_mem_bubble_o         write a bubble into EX/MEM
//   muldiv_start_o          one-cycle start pulse to the mul/div unit
//   stall_cycles_o          cycles with pc_stall_o=1 (saturating)
//   flush_count_o           branch flush events (saturating)
//
// All control outputs are combinational and used in the same cycle.
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_ex_mem_read_i,
    input  logic [4:0]       id_ex_rd_addr_i,
    input  logic             id_ex_is_muldiv_i,
    input  logic             muldiv_done_i,
    input  logic             ex_branch_taken_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_bubble_o,
    output logic             muldiv_start_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_id_ex_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_bubble;
    logic w_muldiv_start;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign w_load_use = id_ex_mem_read_i && (id_ex_rd_addr_i != 5'd0) &&
                        (((id_ex_rd_addr_i == id_rs1_addr_i) && id_uses_rs1_i) ||
                         ((id_ex_rd_addr_i == id_rs2_addr_i) && id_uses_rs2_i));

    always_comb begin
        w_state_next    = r_state;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_muldiv_start  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (id_ex_is_muldiv_i) begin
                    // Mul/div wins over everything: EX is frozen from this cycle.
                    w_muldiv_start  = 1'b1;
                    w_pc_stall      = 1'b1;
                    w_if_id_stall   = 1'b1;
                    w_id_ex_stall   = 1'b1;
                    w_ex_mem_bubble = 1'b1;
                    w_state_next    = ST_MD_WAIT;
                end else if (ex_branch_taken_i) begin
                    // ID holds a wrong-path instruction, so load-use is moot.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    // The bubble clears the load from EX; resolves in one cycle.
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
            default: begin
                if (muldiv_done_i) begin
                    // Done cycle is not stalled: the result advances into EX/MEM.
                    w_state_next = ST_RUN;
                end else begin
                    w_pc_stall      = 1'b1;
                    w_if_id_stall   = 1'b1;
                    w_id_ex_stall   = 1'b1;
                    w_ex_mem_bubble = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_if_id_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // While reset is held every control output is forced low, independent
    // of the inputs.
    assign pc_stall_o      = w_pc_stall      & rst_n;
    assign if_id_stall_o   = w_if_id_stall   & rst_n;
    assign id_ex_stall_o   = w_id_ex_stall   & rst_n;
    assign if_id_flush_o   = w_if_id_flush   & rst_n;
    assign id_ex_flush_o   = w_id_ex_flush   & rst_n;
    assign ex_mem_bubble_o = w_ex_mem_bubble & rst_n;
    assign muldiv_start_o  = w_muldiv_start  & rst_n;
    assign stall_cycles_o  = r_stall_cnt;
    assign flush_count_o   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Drives two instances (CNT_W=32 and CNT_W=4) with the same stimulus and
// compares them each cycle against a behavioural model built from the
// hazard rules: a "mul/div busy" flag plus integer counters clipped at
// 2^W-1. Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mrd, mdv, done, br;

    logic        pcs_a, ifs_a, ids_a, iff_a, idf_a, bub_a, st_a;
    logic [31:0] scnt_a, fcnt_a;
    logic        pcs_b, ifs_b, ids_b, iff_b, idf_b, bub_b, st_b;
    logic [3:0]  scnt_b, fcnt_b;

    hazard_ctrl_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .id_ex_mem_read_i(mrd), .id_ex_rd_addr_i(rd),
        .id_ex_is_muldiv_i(mdv), .muldiv_done_i(done),
        .ex_branch_taken_i(br),
        .pc_stall_o(pcs_a), .if_id_stall_o(ifs_a), .id_ex_stall_o(ids_a),
        .if_id_flush_o(iff_a), .id_ex_flush_o(idf_a),
        .ex_mem_bubble_o(bub_a), .muldiv_start_o(st_a),
        .stall_cycles_o(scnt_a), .flush_count_o(fcnt_a)
    );

    hazard_ctrl_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .id_ex_mem_read_i(mrd), .id_ex_rd_addr_i(rd),
        .id_ex_is_muldiv_i(mdv), .muldiv_done_i(done),
        .ex_branch_taken_i(br),
        .pc_stall_o(pcs_b), .if_id_stall_o(ifs_b), .id_ex_stall_o(ids_b),
        .if_id_flush_o(iff_b), .id_ex_flush_o(idf_b),
        .ex_mem_bubble_o(bub_b), .muldiv_start_o(st_b),
        .stall_cycles_o(scnt_b), .flush_count_o(fcnt_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit     m_busy;
    longint m_st32, m_fl32, m_st4, m_fl4;

    // Packed order: {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
    //                id_ex_flush, ex_mem_bubble, muldiv_start}
    function automatic logic [6:0] model_ctrl();
        bit hz;
        hz = mrd && (rd != 0) && ((rd == rs1 && u1) || (rd == rs2 && u2));
        if (!m_busy) begin
            if (mdv)      return 7'b1110011;
            else if (br)  return 7'b0001100;
            else if (hz)  return 7'b1100100;
            else          return 7'b0000000;
        end
        return done ? 7'b0000000 : 7'b1110010;
    endfunction

    function automatic longint sat_inc(longint v, int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v < lim) ? v + 1 : v;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] d, input logic x1, input logic x2,
                          input logic ld, input logic md, input logic dn,
                          input logic b);
        rs1 = a1; rs2 = a2; rd = d; u1 = x1; u2 = x2;
        mrd = ld; mdv = md; done = dn; br = b;
    endtask

    // One clock: check combinational controls and counters on the falling
    // edge, then advance the model on the rising edge.
    task automatic step(input string tag);
        logic [6:0] e;
        @(negedge clk);
        e = model_ctrl();
        check_val({tag, "/ctrl32"}, {pcs_a, ifs_a, ids_a, iff_a, idf_a, bub_a, st_a}, e);
        check_val({tag, "/ctrl4"},  {pcs_b, ifs_b, ids_b, iff_b, idf_b, bub_b, st_b}, e);
        check_val({tag, "/stall32"}, scnt_a, m_st32);
        check_val({tag, "/flush32"}, fcnt_a, m_fl32);
        check_val({tag, "/stall4"},  scnt_b, m_st4);
        check_val({tag, "/flush4"},  fcnt_b, m_fl4);
        $display("[TB] %-10s md=%0b br=%0b ld=%0b dn=%0b ctrl=%b stall=%0d flush=%0d",
                 tag, mdv, br, mrd, done, e, m_st32, m_fl32);
        @(posedge clk);
        if (e[6]) begin
            m_st32 = sat_inc(m_st32, 32);
            m_st4  = sat_inc(m_st4, 4);
        end
        if (e[3]) begin
            m_fl32 = sat_inc(m_fl32, 32);
            m_fl4  = sat_inc(m_fl4, 4);
        end
        if (!m_busy && mdv)      m_busy = 1'b1;
        else if (m_busy && done) m_busy = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_st32 = 0; m_fl32 = 0; m_st4 = 0; m_fl4 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "/ctrl32"}, {pcs_a, ifs_a, ids_a, iff_a, idf_a, bub_a, st_a}, 0);
        check_val({tag, "/ctrl4"},  {pcs_b, ifs_b, ids_b, iff_b, idf_b, bub_b, st_b}, 0);
        check_val({tag, "/stall32"}, scnt_a, 0);
        check_val({tag, "/flush32"}, fcnt_a, 0);
    endtask

    initial begin
        longint base;
        rst_n = 1'b0;
        set_in(5, 5, 5, 1, 1, 1, 1, 1, 1);
        model_reset();
        #12;
        check_all_zero("reset");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use on rs1, then rd=0 and unused rs2 must not stall
        set_in(5, 0, 5, 1, 0, 1, 0, 0, 0); step("lu_rs1");
        set_in(0, 0, 0, 1, 0, 1, 0, 0, 0); step("lu_rd0");
        set_in(0, 5, 5, 0, 0, 1, 0, 0, 0); step("lu_rs2off");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("idle");

        // DIV with done on the 4th MD_WAIT cycle
        base = m_st32;
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step("div_start");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("div_w1");
        step("div_w2");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); step("div_w3_br");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step("div_done");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("div_after");
        check_val("div_stall_delta", scnt_a - base, 4);

        // Branch beats load-use; done in RUN ignored
        set_in(7, 0, 7, 1, 0, 1, 0, 0, 1); step("br_vs_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step("done_run");

        // Back-to-back mul/div
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step("md1_start");
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); step("md1_done");
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step("md2_start");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step("md2_done");

        // Reset in the middle of MD_WAIT
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step("rst_md");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("rst_wait");
        set_in(3, 3, 3, 1, 1, 1, 1, 0, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step("post_rst");
        step("post_rst2");

        // Saturation of the 4-bit instance: 20-cycle mul/div
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step("sat_start");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) step("sat_wait");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step("sat_done");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("sat_after");
        check_val("sat_stall4", scnt_b, 15);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
